// File: rtl/sig_dump.sv
// rtl/sig_dump.sv - dumps the signature region as hex text lines to a UART byte stream
// Optional macro SIG_DUMP_CRLF_EN: terminate each line with CR LF instead of LF only.
module sig_dump #(
  parameter logic [31:0] SIG_BEGIN = 32'h00005000,
  parameter logic [31:0] SIG_END   = 32'h00008000,
  parameter logic [31:0] TOHOST    = 32'h00005000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snoop_we,
  input  logic [31:0] snoop_addr,
  input  logic [31:0] snoop_wdata,
  output logic        mem_re,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, DONE} state_t;

`ifdef SIG_DUMP_CRLF_EN
  localparam logic [3:0] LAST_IDX = 4'd9;
`else
  localparam logic [3:0] LAST_IDX = 4'd8;
`endif

  state_t      state, state_n;
  logic [31:0] shift_q;
  logic [3:0]  idx_q;
  logic [3:0]  nibble;
  logic [7:0]  char;
  logic [32:0] next_addr;
  logic        addr_end;
  logic        trigger;
  logic        hs;

  assign trigger = snoop_we && (snoop_addr == TOHOST) && (snoop_wdata == 32'h00000001);
  assign hs      = tx_valid && tx_ready;
  assign nibble  = shift_q[31:28];

  // Carry out of the 33-bit sum also ends the dump, so a region touching the top of memory cannot wrap.
  assign next_addr = {1'b0, mem_raddr} + 33'd4;
  assign addr_end  = next_addr[32] || (next_addr[31:0] >= SIG_END);

  always_comb begin
    char = 8'h0A;
    if (idx_q < 4'd8) begin
      char = (nibble < 4'd10) ? (8'h30 + {4'b0000, nibble}) : (8'h57 + {4'b0000, nibble});
    end
`ifdef SIG_DUMP_CRLF_EN
    else if (idx_q == 4'd8) begin
      char = 8'h0D;
    end
`endif
  end

  always_comb begin
    state_n  = state;
    mem_re   = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) state_n = (SIG_BEGIN >= SIG_END) ? DONE : READ;
      end
      READ: begin
        mem_re  = 1'b1;
        busy    = 1'b1;
        state_n = WAIT;
      end
      WAIT: begin
        busy    = 1'b1;
        state_n = SEND;
      end
      SEND: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = char;
        if (hs && idx_q == LAST_IDX) state_n = addr_end ? DONE : READ;
      end
      DONE: begin
        done = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_raddr <= 32'h0;
      shift_q   <= 32'h0;
      idx_q     <= 4'h0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (trigger) mem_raddr <= SIG_BEGIN;
        WAIT: begin
          shift_q <= mem_rdata;
          idx_q   <= 4'h0;
        end
        SEND: begin
          if (hs) begin
            if (idx_q == LAST_IDX) begin
              mem_raddr <= next_addr[31:0];
            end else begin
              idx_q <= idx_q + 4'd1;
              if (idx_q < 4'd8) shift_q <= {shift_q[27:0], 4'h0};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sig_dump.sv
// tb/tb_sig_dump.sv - directed self-checking bench for sig_dump
module tb_sig_dump;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        snoop_we;
  logic [31:0] snoop_addr;
  logic [31:0] snoop_wdata;
  logic        mem_re;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  logic        snoop_we2;
  logic        mem_re2;
  logic [31:0] mem_raddr2;
  logic [7:0]  tx_data2;
  logic        tx_valid2;
  logic        busy2;
  logic        done2;

  int errors = 0;
  int checks = 0;
  logic [7:0] rx[$];
  int re_cnt = 0;
  int tv_cnt = 0;
  int re2_cnt = 0;
  int tv2_cnt = 0;
  string term;
  string exp_s;
  int base;
  int re_base;
  int tv_base;

  always #5 clk = ~clk;

  sig_dump #(.SIG_BEGIN(32'h100), .SIG_END(32'h108)) dut (
    .clk(clk), .rst_n(rst_n),
    .snoop_we(snoop_we), .snoop_addr(snoop_addr), .snoop_wdata(snoop_wdata),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  sig_dump #(.SIG_BEGIN(32'h200), .SIG_END(32'h200)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .snoop_we(snoop_we2), .snoop_addr(snoop_addr), .snoop_wdata(snoop_wdata),
    .mem_re(mem_re2), .mem_raddr(mem_raddr2), .mem_rdata(32'h0),
    .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(1'b1),
    .busy(busy2), .done(done2)
  );

  // Memory model: one-cycle read latency.
  always @(posedge clk) begin
    if (mem_re) begin
      case (mem_raddr)
        32'h100: mem_rdata <= 32'hDEADBEEF;
        32'h104: mem_rdata <= 32'h0000000A;
        default: mem_rdata <= 32'h0;
      endcase
    end
    if (rst_n && tx_valid && tx_ready) rx.push_back(tx_data);
    if (mem_re) re_cnt++;
    if (tx_valid) tv_cnt++;
    if (mem_re2) re2_cnt++;
    if (tx_valid2) tv2_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    snoop_we = 1'b1; snoop_addr = a; snoop_wdata = d;
    @(negedge clk);
    snoop_we = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    for (int i = 0; i < 200 && rx.size() < n; i++) @(negedge clk);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && !done; i++) @(negedge clk);
  endtask

  task automatic chk_stream(input string tag, input int b, input string s);
    chk({tag, "_len"}, 32'(rx.size() - b), 32'(s.len()));
    for (int i = 0; i < s.len(); i++) begin
      if (b + i < rx.size()) chk({tag, "_byte"}, {24'h0, rx[b + i]}, {24'h0, s[i]});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef SIG_DUMP_CRLF_EN
    term = "\r\n";
`else
    term = "\n";
`endif
    exp_s = {"deadbeef", term, "0000000a", term};
    rst_n = 1'b0; snoop_we = 1'b0; snoop_we2 = 1'b0;
    snoop_addr = 32'h0; snoop_wdata = 32'h0; tx_ready = 1'b1;
    do_reset();

    // Reset state
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
    chk("rst_mem_re", {31'h0, mem_re}, 32'h0);
    chk("rst_mem_raddr", mem_raddr, 32'h0);

    // Non-trigger stores are ignored
    re_base = re_cnt; tv_base = tv_cnt;
    store(32'h5000, 32'h2);
    store(32'h5004, 32'h1);
    repeat (5) @(negedge clk);
    chk("ign_busy", {31'h0, busy}, 32'h0);
    chk("ign_mem_re_cnt", 32'(re_cnt - re_base), 32'h0);
    chk("ign_tx_valid_cnt", 32'(tv_cnt - tv_base), 32'h0);

    // Full dump with latency checks
    base = rx.size(); re_base = re_cnt;
    store(32'h5000, 32'h1);
    chk("lat_mem_re", {31'h0, mem_re}, 32'h1);
    chk("lat_raddr", mem_raddr, 32'h100);
    chk("lat_busy", {31'h0, busy}, 32'h1);
    chk("lat_txv_n1", {31'h0, tx_valid}, 32'h0);
    @(negedge clk);
    chk("lat_mem_re_n2", {31'h0, mem_re}, 32'h0);
    chk("lat_txv_n2", {31'h0, tx_valid}, 32'h0);
    @(negedge clk);
    chk("lat_txv_n3", {31'h0, tx_valid}, 32'h1);
    chk("lat_first_char", {24'h0, tx_data}, 32'h64);
    wait_done();
    chk_stream("dump", base, exp_s);
    chk("dump_done", {31'h0, done}, 32'h1);
    chk("dump_busy", {31'h0, busy}, 32'h0);
    chk("dump_reads", 32'(re_cnt - re_base), 32'h2);
    re_base = re_cnt;
    store(32'h5000, 32'h1);
    repeat (3) @(negedge clk);
    chk("done_sticky", {31'h0, done}, 32'h1);
    chk("done_no_reread", 32'(re_cnt - re_base), 32'h0);

    // Backpressure on the 3rd byte
    do_reset();
    base = rx.size();
    store(32'h5000, 32'h1);
    wait_rx(base + 2);
    tx_ready = 1'b0;
    repeat (5) begin
      chk("bp_valid", {31'h0, tx_valid}, 32'h1);
      chk("bp_data", {24'h0, tx_data}, 32'h61);
      @(negedge clk);
    end
    chk("bp_no_accept", 32'(rx.size() - base), 32'h2);
    tx_ready = 1'b1;
    wait_done();
    chk_stream("bp", base, exp_s);

    // Reset mid-dump, with a trigger presented during reset
    do_reset();
    base = rx.size();
    store(32'h5000, 32'h1);
    wait_rx(base + 3);
    rst_n = 1'b0;
    snoop_we = 1'b1; snoop_addr = 32'h5000; snoop_wdata = 32'h1;
    @(negedge clk);
    rst_n = 1'b1; snoop_we = 1'b0;
    chk("mid_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("mid_tx_data", {24'h0, tx_data}, 32'h0);
    chk("mid_mem_re", {31'h0, mem_re}, 32'h0);
    chk("mid_raddr", mem_raddr, 32'h0);
    chk("mid_busy", {31'h0, busy}, 32'h0);
    chk("mid_done", {31'h0, done}, 32'h0);
    @(negedge clk);
    chk("rst_trig_ignored", {31'h0, busy}, 32'h0);
    base = rx.size();
    store(32'h5000, 32'h1);
    chk("restart_mem_re", {31'h0, mem_re}, 32'h1);
    chk("restart_raddr", mem_raddr, 32'h100);
    wait_done();
    chk_stream("restart", base, exp_s);

    // Empty region goes straight to done
    @(negedge clk);
    snoop_we2 = 1'b1; snoop_addr = 32'h5000; snoop_wdata = 32'h1;
    @(negedge clk);
    snoop_we2 = 1'b0;
    chk("empty_done_n1", {31'h0, done2}, 32'h1);
    @(negedge clk);
    chk("empty_done_n2", {31'h0, done2}, 32'h1);
    chk("empty_busy", {31'h0, busy2}, 32'h0);
    chk("empty_tx_data", {24'h0, tx_data2}, 32'h0);
    chk("empty_reads", 32'(re2_cnt), 32'h0);
    chk("empty_tx_valid", 32'(tv2_cnt), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sig_dump.md
SIG_DUMP -- requirements
Module: sig_dump

Interface
REQ-001 SHALL have parameter SIG_BEGIN, default 32'h00005000, byte address of the first signature word (word-aligned).
REQ-002 SHALL have parameter SIG_END, default 32'h00008000, exclusive byte end address of the signature region (word-aligned).
REQ-003 SHALL have parameter TOHOST, default 32'h00005000, byte address whose store of 32'h00000001 triggers the dump.
REQ-004 SHALL have a single clock domain and a synchronous, active-low reset.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port snoop_we, input, 1 bit: data-memory store strobe.
REQ-008 SHALL have port snoop_addr, input, 32 bits: store byte address.
REQ-009 SHALL have port snoop_wdata, input, 32 bits: store data.
REQ-010 SHALL have port mem_re, output, 1 bit: memory read strobe.
REQ-011 SHALL have port mem_raddr, output, 32 bits: read byte address.
REQ-012 SHALL have port mem_rdata, input, 32 bits: read data, valid exactly one cycle after mem_re.
REQ-013 SHALL have port tx_data, output, 8 bits: ASCII byte toward the UART transmitter.
REQ-014 SHALL have port tx_valid, output, 1 bit: tx_data valid.
REQ-015 SHALL have port tx_ready, input, 1 bit: consumer accepts the byte when tx_valid && tx_ready.
REQ-016 SHALL have port busy, output, 1 bit: dump in progress.
REQ-017 SHALL have port done, output, 1 bit: dump complete, sticky.

Function
REQ-018 SHALL implement the FSM states IDLE, READ, WAIT, SEND and DONE.
REQ-019 IDLE SHALL move to READ, with mem_raddr=SIG_BEGIN, when snoop_we && snoop_addr==TOHOST && snoop_wdata==1; any other store SHALL be ignored.
REQ-020 If SIG_BEGIN>=SIG_END, the trigger SHALL go directly to DONE with no reads and no tx bytes.
REQ-021 READ SHALL assert mem_re for exactly one cycle, then go to WAIT.
REQ-022 WAIT SHALL capture mem_rdata into a 32-bit shift register, clear the character index, then go to SEND.
REQ-023 Latency: trigger sampled at edge N; mem_re high in cycle N+1; first tx_valid high in cycle N+3.
REQ-024 SEND SHALL emit 8 hex characters, most-significant nibble first, followed by the line terminator.
REQ-025 Hex encoding: nibble 0-9 -> 8'h30+n; nibble 10-15 -> 8'h57+n (lowercase a-f).
REQ-026 tx_data SHALL advance only on a tx_valid && tx_ready handshake; while tx_valid && !tx_ready, tx_valid and tx_data SHALL be held stable.
REQ-027 After the terminator handshake, mem_raddr SHALL increment by 4; if the new address >= SIG_END the FSM SHALL go to DONE, else to READ.
REQ-028 Address arithmetic SHALL be 32-bit unsigned; the end comparison SHALL use >= so that wrap-around cannot extend the dump.
REQ-029 busy SHALL be 1 in READ, WAIT and SEND, and 0 otherwise.
REQ-030 done SHALL be 1 only in DONE.
REQ-031 DONE SHALL be terminal until reset; further triggers SHALL be ignored.
REQ-032 tx_valid SHALL be 0 in all states except SEND.

Reset
REQ-033 When rst_n==0 at a clock edge: state=IDLE, tx_valid=0, tx_data=0, mem_re=0, mem_raddr=0, busy=0, done=0, shift register and character index cleared.
REQ-034 Reset asserted mid-dump SHALL abort the dump without completing the byte in flight; a later trigger SHALL restart from SIG_BEGIN.
REQ-035 A trigger sampled in the same cycle as rst_n==0 SHALL be ignored.

Configuration
REQ-036 Macro SIG_DUMP_CRLF_EN defined: the terminator SHALL be 8'h0D then 8'h0A, 10 bytes per word.
REQ-037 Macro SIG_DUMP_CRLF_EN undefined: the terminator SHALL be 8'h0A only, 9 bytes per word.

Verification
REQ-038 Scenario SIG_BEGIN=0x100, SIG_END=0x108, mem words 0xDEADBEEF and 0x0000000A, tx_ready=1, trigger: bytes "deadbeef\n0000000a\n" (18 bytes), then done=1 and busy=0.
REQ-039 Scenario: same setup, tx_ready held low for 5 cycles after the 3rd byte: tx_data=8'h61 ('a') held stable all 5 cycles; no byte lost or duplicated.
REQ-040 Scenario: store 2 to TOHOST, then store 1 to TOHOST+4: FSM stays in IDLE, mem_re never asserted, tx_valid stays 0.
REQ-041 Scenario: rst_n low for 1 cycle after 3 accepted bytes: all outputs return to reset values the next cycle; re-trigger reads 0x100 first.
REQ-042 Scenario SIG_BEGIN==SIG_END=0x200, trigger: done=1 two cycles after the trigger edge, zero tx handshakes.
REQ-043 Scenario with SIG_DUMP_CRLF_EN defined, one word 0x01234567: bytes "01234567\r\n" (10 bytes).
